// File: rtl/stream_packer_db.sv
// stream_packer_db: packs W-bit elements into BEAT_W-bit beats with byte
// strobes and end-of-transfer marking. A fill accumulator feeds an output
// holding register so a full beat can wait on m_ready while the next beat
// keeps filling at one element per cycle. Supports an early flush of a
// partial beat and counts accepted beats per transfer.
module stream_packer_db #(
  parameter int unsigned W         = 16,
  parameter int unsigned BEAT_W    = 128,
  parameter bit          LSB_FIRST = 1'b1,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [W-1:0]          s_data,
  input  logic                  s_last,
  input  logic                  s_flush,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [BEAT_W-1:0]     m_data,
  output logic [BEAT_W/8-1:0]   m_strb,
  output logic                  m_last,
  output logic [CNT_W-1:0]      beat_cnt
);

  localparam int unsigned ELS      = BEAT_W / W;
  localparam int unsigned BPE      = W / 8;
  localparam int unsigned SB       = BEAT_W / 8;
  localparam int unsigned CNT_BITS = (ELS > 1) ? $clog2(ELS) : 1;

  if ((W % 8) != 0 || (BEAT_W % 8) != 0 || (BEAT_W % W) != 0 || (BEAT_W / W) < 1) begin : g_param_check
    $fatal(1, "stream_packer_db: illegal W/BEAT_W combination");
  end

  // Fill accumulator
  logic [BEAT_W-1:0]   acc_data_q, acc_data_d;
  logic [SB-1:0]       acc_strb_q, acc_strb_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                sealed_q, sealed_d;
  logic                acc_last_q, acc_last_d;

  // Output holding register
  logic                out_valid_q, out_valid_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic [SB-1:0]       out_strb_q, out_strb_d;
  logic                out_last_q, out_last_d;
  logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;

  logic                accept, pop, out_free, last_slot, seal_now, beat_rdy, beat_last;
  logic [BEAT_W-1:0]   ins_data;
  logic [SB-1:0]       ins_strb;

  assign accept    = s_valid && !sealed_q;
  assign pop       = out_valid_q && m_ready;
  assign out_free  = !out_valid_q || pop;
  assign last_slot = (cnt_q == CNT_BITS'(ELS - 1));
  // Seal either on the accepting edge, or a flush-only seal of a non-empty
  // partial beat when no element arrives.
  assign seal_now  = (accept && (last_slot || s_last || s_flush)) ||
                     (!s_valid && !sealed_q && s_flush && (cnt_q != '0));
  assign beat_rdy  = sealed_q || seal_now;
  assign beat_last = sealed_q ? acc_last_q : (accept && s_last);

  // Next-state: element insertion, sealing, acc->out transfer, pop, beat count
  always_comb begin
    ins_data    = acc_data_q;
    ins_strb    = acc_strb_q;
    acc_data_d  = acc_data_q;
    acc_strb_d  = acc_strb_q;
    cnt_d       = cnt_q;
    sealed_d    = sealed_q;
    acc_last_d  = acc_last_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_strb_d  = out_strb_q;
    out_last_d  = out_last_q;
    beat_cnt_d  = beat_cnt_q;

    if (accept) begin
      for (int unsigned k = 0; k < ELS; k++) begin
        if (cnt_q == CNT_BITS'(k)) begin
          ins_data[(LSB_FIRST ? k : (ELS - 1 - k)) * W +: W]     = s_data;
          ins_strb[(LSB_FIRST ? k : (ELS - 1 - k)) * BPE +: BPE] = '1;
        end
      end
    end

    if (pop) begin
      out_valid_d = 1'b0;
      beat_cnt_d  = out_last_q ? '0 : beat_cnt_q + CNT_W'(1);
    end

    // A ready beat moves straight into out whenever out is empty or being
    // popped this edge, so m_valid never bubbles at beat boundaries.
    if (beat_rdy && out_free) begin
      out_valid_d = 1'b1;
      out_data_d  = ins_data;
      out_strb_d  = ins_strb;
      out_last_d  = beat_last;
      acc_data_d  = '0;
      acc_strb_d  = '0;
      cnt_d       = '0;
      sealed_d    = 1'b0;
      acc_last_d  = 1'b0;
    end else if (seal_now) begin
      acc_data_d  = ins_data;
      acc_strb_d  = ins_strb;
      sealed_d    = 1'b1;
      acc_last_d  = beat_last;
    end else if (accept) begin
      acc_data_d  = ins_data;
      acc_strb_d  = ins_strb;
      cnt_d       = cnt_q + CNT_BITS'(1);
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_data_q  <= '0;
      acc_strb_q  <= '0;
      cnt_q       <= '0;
      sealed_q    <= 1'b0;
      acc_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_strb_q  <= '0;
      out_last_q  <= 1'b0;
      beat_cnt_q  <= '0;
    end else begin
      acc_data_q  <= acc_data_d;
      acc_strb_q  <= acc_strb_d;
      cnt_q       <= cnt_d;
      sealed_q    <= sealed_d;
      acc_last_q  <= acc_last_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_strb_q  <= out_strb_d;
      out_last_q  <= out_last_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign s_ready  = !sealed_q;
  assign m_valid  = out_valid_q;
  assign m_data   = out_data_q;
  assign m_strb   = out_strb_q;
  assign m_last   = out_last_q;
  assign beat_cnt = beat_cnt_q;

endmodule

// File: tb/tb_stream_packer_db.sv
// Directed bench for stream_packer_db: an LSB-first and an MSB-first
// instance share the same input stimulus; each step drives inputs, waits
// for the clock edge and checks registered outputs 1 ns later.
module tb_stream_packer_db;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         s_valid, s_last, s_flush, m_ready;
  logic [15:0]  s_data;
  logic         s_ready, m_valid, m_last;
  logic [127:0] m_data;
  logic [15:0]  m_strb;
  logic [15:0]  beat_cnt;
  logic         s_ready_b, m_valid_b, m_last_b;
  logic [127:0] m_data_b;
  logic [15:0]  m_strb_b;
  logic [15:0]  beat_cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stream_packer_db #(.W(16), .BEAT_W(128), .LSB_FIRST(1'b1), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .s_flush(s_flush), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_strb(m_strb), .m_last(m_last), .beat_cnt(beat_cnt)
  );

  stream_packer_db #(.W(16), .BEAT_W(128), .LSB_FIRST(1'b0), .CNT_W(16)) u_dut_msb (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready_b), .s_data(s_data),
    .s_last(s_last), .s_flush(s_flush), .m_valid(m_valid_b), .m_ready(m_ready),
    .m_data(m_data_b), .m_strb(m_strb_b), .m_last(m_last_b), .beat_cnt(beat_cnt_b)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    s_valid = 1'b0; s_last = 1'b0; s_flush = 1'b0; s_data = '0;
  endtask

  initial begin
    rst_n = 1'b0; m_ready = 1'b0;
    idle();
    tick(); tick();
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_strb", m_strb, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_beat_cnt", beat_cnt, 0);
    chk("rst_s_ready", s_ready, 1);
    rst_n = 1'b1;
    tick();

    // 16 elements, m_ready=1, s_last on the 16th
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'(i + 1); s_last = (i == 15);
      chk("t1_s_ready", s_ready, 1);
      tick();
      if (i == 7) begin
        chk("t1_b0_valid", m_valid, 1);
        chk("t1_b0_data", m_data, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        chk("t1_b0_strb", m_strb, 16'hFFFF);
        chk("t1_b0_last", m_last, 0);
        chk("t1_b0_cnt", beat_cnt, 0);
      end
      if (i == 8) chk("t1_cnt_after_b0", beat_cnt, 1);
      if (i == 15) begin
        chk("t1_b1_valid", m_valid, 1);
        chk("t1_b1_data", m_data, 128'h0010_000F_000E_000D_000C_000B_000A_0009);
        chk("t1_b1_last", m_last, 1);
      end
    end
    idle();
    tick();
    chk("t1_end_valid", m_valid, 0);
    chk("t1_end_cnt", beat_cnt, 0);

    // 3 elements, s_last on the third; held with m_ready=0
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = 16'hAAAA; tick();
    s_data = 16'hBBBB; tick();
    s_data = 16'hCCCC; s_last = 1'b1; tick();
    idle();
    chk("t2_valid", m_valid, 1);
    chk("t2_data", m_data, 128'h0000_0000_0000_0000_0000_CCCC_BBBB_AAAA);
    chk("t2_strb", m_strb, 16'h003F);
    chk("t2_last", m_last, 1);
    chk("t2_msb_data", m_data_b, 128'hAAAA_BBBB_CCCC_0000_0000_0000_0000_0000);
    chk("t2_msb_strb", m_strb_b, 16'hFC00);
    m_ready = 1'b1;
    tick();
    chk("t2_pop_valid", m_valid, 0);
    chk("t2_pop_cnt", beat_cnt, 0);

    // single element with s_last
    s_valid = 1'b1; s_data = 16'h1234; s_last = 1'b1; tick();
    idle();
    chk("t3_msb_data", m_data_b, 128'h1234_0000_0000_0000_0000_0000_0000_0000);
    chk("t3_msb_strb", m_strb_b, 16'hC000);
    chk("t3_msb_last", m_last_b, 1);
    chk("t3_lsb_data", m_data, 128'h0000_0000_0000_0000_0000_0000_0000_1234);
    chk("t3_lsb_strb", m_strb, 16'h0003);
    tick();
    chk("t3_pop_valid", m_valid, 0);

    // backpressure: 16 elements with m_ready=0
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0101 + i); s_last = (i == 15);
      chk("t4_s_ready", s_ready, 1);
      tick();
    end
    chk("t4_s_ready_full", s_ready, 0);
    chk("t4_hold_valid", m_valid, 1);
    chk("t4_hold_data", m_data, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    s_data = 16'hDEAD; s_last = 1'b0;
    tick(); tick();
    chk("t4_stall_data", m_data, 128'h0108_0107_0106_0105_0104_0103_0102_0101);
    chk("t4_stall_ready", s_ready, 0);
    chk("t4_stall_last", m_last, 0);
    idle();
    m_ready = 1'b1;
    tick();
    chk("t4_b1_valid", m_valid, 1);
    chk("t4_b1_data", m_data, 128'h0110_010F_010E_010D_010C_010B_010A_0109);
    chk("t4_b1_last", m_last, 1);
    chk("t4_b1_cnt", beat_cnt, 1);
    chk("t4_s_ready_back", s_ready, 1);
    tick();
    chk("t4_end_valid", m_valid, 0);
    chk("t4_end_cnt", beat_cnt, 0);

    // flush of a 5-element partial beat
    for (int i = 0; i < 5; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0011 + i); tick();
    end
    chk("t5_no_beat_yet", m_valid, 0);
    idle(); s_flush = 1'b1; tick();
    chk("t5_fl_valid", m_valid, 1);
    chk("t5_fl_data", m_data, 128'h0000_0000_0000_0015_0014_0013_0012_0011);
    chk("t5_fl_strb", m_strb, 16'h03FF);
    chk("t5_fl_last", m_last, 0);
    s_flush = 1'b0; s_valid = 1'b1; s_data = 16'h0777; s_last = 1'b1; tick();
    chk("t5_slot0_valid", m_valid, 1);
    chk("t5_slot0_data", m_data, 128'h0000_0000_0000_0000_0000_0000_0000_0777);
    chk("t5_slot0_strb", m_strb, 16'h0003);
    chk("t5_slot0_cnt", beat_cnt, 1);
    idle(); s_flush = 1'b1; tick();
    chk("t5_pop_cnt", beat_cnt, 0);
    chk("t5_empty_flush1", m_valid, 0);
    tick();
    chk("t5_empty_flush2", m_valid, 0);
    idle();

    // asynchronous reset with a held beat and a 4-element partial
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0021 + i); tick();
    end
    idle(); tick();
    chk("t6_pre_cnt", beat_cnt, 1);
    m_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0031 + i); tick();
    end
    idle();
    chk("t6_pre_valid", m_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", m_valid, 0);
    chk("t6_rst_strb", m_strb, 0);
    chk("t6_rst_cnt", beat_cnt, 0);
    chk("t6_rst_ready", s_ready, 1);
    #2 rst_n = 1'b1;
    m_ready = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1; s_data = 16'(16'h0041 + i); tick();
    end
    idle();
    chk("t6_new_valid", m_valid, 1);
    chk("t6_new_data", m_data, 128'h0048_0047_0046_0045_0044_0043_0042_0041);
    chk("t6_new_strb", m_strb, 16'hFFFF);
    chk("t6_new_last", m_last, 0);
    tick();
    chk("t6_new_cnt", beat_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
